// File: rtl/uart_tx.sv
// 16550-style UART transmitter: holding register (or FIFO when TX_FIFO_EN is
// defined) feeding a shift register, OVS baud ticks per serial bit.
module uart_tx #(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bclk,
    input  logic [7:0]                  LCR,
    input  logic [7:0]                  thr_data,
    input  logic                        thr_wr,
    output logic                        thr_empty,
    output logic                        tsr_empty,
    output logic                        wr_drop,
`ifdef TX_FIFO_EN
    output logic [$clog2(FIFO_DEPTH):0] tx_fifo_cnt,
`endif
    output logic                        txd
);

    localparam int TW = $clog2(2 * OVS);

    localparam logic [TW-1:0] BIT_LAST    = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'((OVS * 3) / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    tsr_reg, tsr_next;
    logic [5:0]    cfg_reg, cfg_next;
    logic          par_reg, par_next;
    logic          txd_reg, txd_next;
    logic          thr_empty_reg, thr_empty_next;
    logic          tsr_empty_reg, tsr_empty_next;
    logic          wr_drop_reg;

    logic          pop;
    logic          wr_accept;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_none_next;

    logic          unused_dlab;
    assign unused_dlab = &{1'b0, LCR[7]};

`ifdef TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;

    // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
    assign wr_accept = thr_wr && (thr_empty_reg || pop);
    assign src_valid = (count_reg != '0);
    assign src_data  = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    assign src_none_next  = (count_next == '0);
    assign thr_empty_next = (count_next < (AW + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= thr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    assign tx_fifo_cnt = count_reg;
`else
    logic       hold_valid_reg;
    logic [7:0] hold_data_reg;

    assign wr_accept = thr_wr && thr_empty_reg;
    assign src_valid = hold_valid_reg;
    assign src_data  = hold_data_reg;

    assign src_none_next  = !((hold_valid_reg && !pop) || wr_accept);
    assign thr_empty_next = src_none_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_valid_reg <= 1'b0;
        end else if (wr_accept) begin
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            hold_data_reg <= thr_data;
        end
    end
`endif

    // Parity is taken at load time over only the active word-length bits.
    logic [3:0] load_len;
    logic [7:0] load_mask;
    logic       load_xor;
    logic       load_par;

    assign load_len = 4'd5 + {2'b00, LCR[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign load_mask[gi] = (4'(gi) < load_len);
        end
    endgenerate

    assign load_xor = ^(src_data & load_mask);
    assign load_par = LCR[5] ? ~LCR[4] : (LCR[4] ? load_xor : ~load_xor);

    logic [2:0]    n_last;
    logic [TW-1:0] stop_last;
    logic [TW-1:0] cur_last;
    logic          tick_end;

    assign n_last = 3'd4 + {1'b0, cfg_reg[1:0]};

    always_comb begin
        if (!cfg_reg[2]) begin
            stop_last = BIT_LAST;
        end else if (cfg_reg[1:0] == 2'd0) begin
            stop_last = STOP15_LAST;
        end else begin
            stop_last = STOP2_LAST;
        end
    end

    assign cur_last = (state_reg == ST_STOP) ? stop_last : BIT_LAST;
    assign tick_end = bclk && (tick_reg == cur_last);

    always_comb begin
        logic do_load;
        do_load    = 1'b0;
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        tsr_next   = tsr_reg;
        cfg_next   = cfg_reg;
        par_next   = par_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;

        if (bclk && (state_reg != ST_IDLE)) begin
            tick_next = tick_reg + TW'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                txd_next = 1'b1;
                if (src_valid) begin
                    do_load = 1'b1;
                end
            end
            ST_START: begin
                if (tick_end) begin
                    tick_next  = '0;
                    bit_next   = 3'd0;
                    state_next = ST_DATA;
                    txd_next   = tsr_reg[0];
                end
            end
            ST_DATA: begin
                if (tick_end) begin
                    tick_next = '0;
                    if (bit_reg == n_last) begin
                        if (cfg_reg[3]) begin
                            state_next = ST_PARITY;
                            txd_next   = par_reg;
                        end else begin
                            state_next = ST_STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        tsr_next = {1'b0, tsr_reg[7:1]};
                        txd_next = tsr_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick_end) begin
                    tick_next  = '0;
                    state_next = ST_STOP;
                    txd_next   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_end) begin
                    tick_next = '0;
                    if (src_valid) begin
                        do_load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        txd_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
                txd_next   = 1'b1;
            end
        endcase

        // Back-to-back frames reuse this path straight out of STOP, no idle bit.
        if (do_load) begin
            pop        = 1'b1;
            tsr_next   = src_data;
            cfg_next   = LCR[5:0];
            par_next   = load_par;
            tick_next  = '0;
            bit_next   = 3'd0;
            state_next = ST_START;
            txd_next   = 1'b0;
        end
    end

    assign tsr_empty_next = src_none_next && (state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            tick_reg      <= '0;
            bit_reg       <= 3'd0;
            tsr_reg       <= 8'd0;
            cfg_reg       <= 6'd0;
            par_reg       <= 1'b0;
            txd_reg       <= 1'b1;
            thr_empty_reg <= 1'b1;
            tsr_empty_reg <= 1'b1;
            wr_drop_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            bit_reg       <= bit_next;
            tsr_reg       <= tsr_next;
            cfg_reg       <= cfg_next;
            par_reg       <= par_next;
            txd_reg       <= txd_next;
            thr_empty_reg <= thr_empty_next;
            tsr_empty_reg <= tsr_empty_next;
            wr_drop_reg   <= thr_wr && !wr_accept;
        end
    end

    // Break overrides the line after the register so release is immediate.
    assign txd       = txd_reg & ~LCR[6];
    assign thr_empty = thr_empty_reg;
    assign tsr_empty = tsr_empty_reg;
    assign wr_drop   = wr_drop_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a tick-list frame model checked every cycle,
// plus hand-computed frame latencies and bit values.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bclk = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic [7:0] thr_data = 8'h00;
    logic       thr_wr = 1'b0;
    logic       thr_empty, tsr_empty, wr_drop, txd;
`ifdef TX_FIFO_EN
    logic [4:0] fifo_cnt;
`endif

    uart_tx #(.OVS(16), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .LCR       (lcr),
        .thr_data  (thr_data),
        .thr_wr    (thr_wr),
        .thr_empty (thr_empty),
        .tsr_empty (tsr_empty),
        .wr_drop   (wr_drop),
`ifdef TX_FIFO_EN
        .tx_fifo_cnt(fifo_cnt),
`endif
        .txd       (txd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int cyc_cnt = 0;
    int bdiv = 1;
    int bcnt = 0;
    bit brand = 1'b0;
    logic samp [12];

    task automatic chk_b(input string nm, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    // Model: each frame is a list of line levels, one entry per baud tick.
    bit         m_busy = 1'b0;
    bit         m_hval = 1'b0;
    logic [7:0] m_hbyte = 8'h00;
    bit         m_drop = 1'b0;
    bit         m_wave [$];

    task automatic build_frame(input logic [7:0] d, input logic [7:0] l);
        int  n;
        int  stop_ticks;
        bit  x;
        bit  p;
        n = 5 + int'(l[1:0]);
        x = 1'b0;
        m_wave.delete();
        for (int t = 0; t < 16; t++) m_wave.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            x = x ^ d[i];
            for (int t = 0; t < 16; t++) m_wave.push_back(d[i]);
        end
        if (l[3]) begin
            p = l[5] ? ~l[4] : (l[4] ? x : ~x);
            for (int t = 0; t < 16; t++) m_wave.push_back(p);
        end
        stop_ticks = !l[2] ? 16 : ((n == 5) ? 24 : 32);
        for (int t = 0; t < stop_ticks; t++) m_wave.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        bit pre_hval;
        bit load;
        if (!reset) begin
            m_busy = 1'b0;
            m_hval = 1'b0;
            m_drop = 1'b0;
            m_wave.delete();
        end else begin
            pre_hval = m_hval;
            load = 1'b0;
            if (m_busy) begin
                if (bclk) begin
                    void'(m_wave.pop_front());
                    if (m_wave.size() == 0) begin
                        m_busy = 1'b0;
                        if (pre_hval) load = 1'b1;
                    end
                end
            end else if (pre_hval) begin
                load = 1'b1;
            end
            if (load) begin
                build_frame(m_hbyte, lcr);
                m_busy = 1'b1;
            end
            m_drop = thr_wr && pre_hval;
            m_hval = (pre_hval && !load) || (thr_wr && !pre_hval);
            if (thr_wr && !pre_hval) m_hbyte = thr_data;
        end
    end

    always @(negedge clk) begin
        logic exp_txd;
        if (chk_en) begin
            exp_txd = (m_busy ? m_wave[0] : 1'b1) & ~lcr[6];
            chk_b("txd", txd, exp_txd);
            chk_b("thr_empty", thr_empty, !m_hval);
            chk_b("tsr_empty", tsr_empty, !m_hval && !m_busy);
            chk_b("wr_drop", wr_drop, m_drop);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            thr_wr = 1'b0;
            if (brand) begin
                bclk = ($urandom_range(0, 2) == 0);
            end else begin
                bcnt = (bcnt + 1) % bdiv;
                bclk = (bcnt == 0);
            end
        end
    endtask

    task automatic wr(input logic [7:0] d);
        thr_data = d;
        thr_wr = 1'b1;
        cyc(1);
        $display("write 0x%02h lcr=0x%02h at cycle %0d", d, lcr, cyc_cnt);
    endtask

    // Runs until the transmitter is idle, sampling txd mid-way through each bit.
    task automatic run_frame(input int maxc, output int n);
        int t0;
        t0 = cyc_cnt;
        n = 0;
        for (int k = 0; k < 12; k++) samp[k] = 1'bx;
        do begin
            cyc(1);
            n = cyc_cnt - t0;
            if (((n - 1) % 16) == 8 && ((n - 1) / 16) < 12) samp[(n - 1) / 16] = txd;
        end while (!tsr_empty && n < maxc);
        if (!tsr_empty) chk_b("frame_timeout", tsr_empty, 1'b1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (!tsr_empty && n < maxc) begin
            cyc(1);
            n++;
        end
        chk_b("idle_timeout", tsr_empty, 1'b1);
    endtask

    initial begin
        #1_200_000;
        bad++;
        $display("FAIL watchdog: got still running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        int t0;
        logic [9:0] expv;

        // Reset held three cycles, then idle with a slow tick.
        reset = 1'b0;
        bdiv = 4;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        chk_b("rst_txd", txd, 1'b1);
        chk_b("rst_thre", thr_empty, 1'b1);
        chk_b("rst_temt", tsr_empty, 1'b1);
        chk_b("rst_drop", wr_drop, 1'b0);
        reset = 1'b1;
        cyc(60);
        chk_b("idle_txd", txd, 1'b1);
        chk_b("idle_temt", tsr_empty, 1'b1);

        // 8N1 0x55 at one tick per clock.
        bdiv = 1;
        lcr = 8'h03;
        cyc(3);
        wr(8'h55);
        run_frame(400, n);
        chk_i("8n1_latency", n, 161);
        expv = 10'b1010101010;
        for (int k = 0; k < 10; k++) chk_b("8n1_bit", samp[k], expv[k]);
        cyc(5);

        lcr = 8'h1B;
        wr(8'h07);
        run_frame(400, n);
        chk_i("8e1_latency", n, 177);
        chk_b("8e1_parity", samp[9], 1'b1);
        cyc(5);
        lcr = 8'h0B;
        wr(8'h07);
        run_frame(400, n);
        chk_b("8o1_parity", samp[9], 1'b0);
        cyc(5);
        lcr = 8'h3B;
        wr(8'h07);
        run_frame(400, n);
        chk_b("stick_even", samp[9], 1'b0);
        cyc(5);
        lcr = 8'h2B;
        wr(8'h06);
        run_frame(400, n);
        chk_b("stick_odd", samp[9], 1'b1);
        cyc(5);

        // Stop-bit lengths.
        lcr = 8'h04;
        wr(8'hFF);
        run_frame(400, n);
        chk_i("5n15_latency", n, 121);
        for (int k = 1; k < 6; k++) chk_b("5n_data", samp[k], 1'b1);
        cyc(5);
        lcr = 8'h07;
        wr(8'h00);
        run_frame(400, n);
        chk_i("8n2_latency", n, 177);
        cyc(5);

        // Back-to-back frames and a dropped write.
        lcr = 8'h03;
        wr(8'hA1);
        t0 = cyc_cnt;
        cyc(20);
        wr(8'hB2);
        cyc(10);
        chk_b("full_thre", thr_empty, 1'b0);
        wr(8'hC3);
        chk_b("drop_pulse", wr_drop, 1'b1);
        cyc(1);
        chk_b("drop_clear", wr_drop, 1'b0);
        wait_idle(700);
        chk_i("b2b_latency", cyc_cnt - t0, 321);
        cyc(200);
        chk_b("c3_not_sent", tsr_empty, 1'b1);

        // Break mid-frame.
        wr(8'h3C);
        t0 = cyc_cnt;
        cyc(20);
        lcr = 8'h43;
        cyc(20);
        chk_b("break_txd", txd, 1'b0);
        cyc(20);
        lcr = 8'h03;
        wait_idle(400);
        chk_i("break_latency", cyc_cnt - t0, 161);
        cyc(5);

        // Reset in the middle of the data bits.
        wr(8'hF0);
        cyc(50);
        chk_b("pre_rst_txd", txd, 1'b0);
        reset = 1'b0;
        cyc(1);
        chk_b("midrst_txd", txd, 1'b1);
        chk_b("midrst_temt", tsr_empty, 1'b1);
        chk_b("midrst_thre", thr_empty, 1'b1);
        reset = 1'b1;
        cyc(10);

        // Randomised traffic.
        for (int it = 0; it < 50; it++) begin
            int nw;
            brand = ($urandom_range(0, 1) == 1);
            bdiv = $urandom_range(1, 3);
            lcr = 8'($urandom());
            lcr[6] = 1'b0;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                wr(8'($urandom()));
                cyc($urandom_range(0, 200));
            end
            if ($urandom_range(0, 5) == 0) begin
                lcr[6] = 1'b1;
                cyc($urandom_range(1, 50));
                lcr[6] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b0;
                cyc($urandom_range(1, 3));
                reset = 1'b1;
            end
            cyc($urandom_range(0, 300));
        end
        brand = 1'b0;
        bdiv = 1;
        wait_idle(2000);
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
